// File: rtl/icg_seq_pkg.sv
// Shared types and helpers for the clock-gate enable sequencer.
package icg_seq_pkg;

    typedef enum logic [1:0] {
        StOff,
        StWake,
        StOn,
        StIdle
    } dom_state_t;

    // Width of a down-counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/icg_dom_fsm.sv
// Per-domain gate FSM: OFF -> WAKE -> ON <-> IDLE -> OFF, with wake and idle counters.
module icg_dom_fsm
    import icg_seq_pkg::*;
#(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic CLK,
    input  logic RN,
    input  logic grant,
    input  logic req,
    input  logic busy,
    output logic gate_en,
    output logic ack,
    output logic dom_on,
    output logic pending
);

    localparam int unsigned WW = cnt_width(WAKE_CYC);
    localparam int unsigned IW = cnt_width(IDLE_CYC);
    localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYC);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYC);

    dom_state_t    state_q, state_d;
    logic [WW-1:0] wake_q, wake_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          ack_q, on_q;

    always_comb begin
        state_d = state_q;
        wake_d  = wake_q;
        idle_d  = idle_q;
        unique case (state_q)
            StOff: begin
                if (grant) begin
                    state_d = StWake;
                    wake_d  = WAKE_LOAD;
                end
            end
            StWake: begin
                // Transition on the edge where the count reaches zero.
                if (wake_q <= WW'(1)) begin
                    state_d = StOn;
                    wake_d  = '0;
                end else begin
                    wake_d = wake_q - WW'(1);
                end
            end
            StOn: begin
                if (!req && !busy) begin
                    state_d = StIdle;
                    idle_d  = IDLE_LOAD;
                end
            end
            StIdle: begin
                // A request always wins over expiry.
                if (req) begin
                    state_d = StOn;
                end else if (busy) begin
                    idle_d = IDLE_LOAD;
                end else if (idle_q <= IW'(1)) begin
                    state_d = StOff;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q - IW'(1);
                end
            end
            default: state_d = StOff;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= StOff;
            wake_q  <= '0;
            idle_q  <= '0;
            ack_q   <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wake_q  <= wake_d;
            idle_q  <= idle_d;
            ack_q   <= (state_d == StOn);
            on_q    <= (state_d != StOff);
        end
    end

    assign gate_en = on_q;
    assign dom_on  = on_q;
    assign ack     = ack_q;
    assign pending = (state_q == StOff) && req;

endmodule

// File: rtl/icg_enable_sequencer.sv
// Staggered round-robin enable sequencer for N_DOM clock-gate cells, with test-enable override.
module icg_enable_sequencer
    import icg_seq_pkg::*;
#(
    parameter int unsigned N_DOM       = 4,
    parameter int unsigned WAKE_CYC    = 2,
    parameter int unsigned IDLE_CYC    = 16,
    parameter int unsigned STAGGER_CYC = 4
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             TE,
    input  logic [N_DOM-1:0] req,
    input  logic [N_DOM-1:0] busy,
    output logic [N_DOM-1:0] gate_en,
    output logic [N_DOM-1:0] ack,
    output logic [N_DOM-1:0] dom_on
);

    localparam int unsigned PW = $clog2(N_DOM);
    localparam int unsigned SW = cnt_width(STAGGER_CYC);

    logic [N_DOM-1:0] pending, grant, gate_q;
    logic [PW-1:0]    ptr_q, ptr_d, idx;
    logic [SW-1:0]    stg_q, stg_d;
    logic             found;
    int unsigned      sum;

    // Round-robin search from the pointer; only one grant per edge and only when
    // the stagger window has fully elapsed.
    always_comb begin
        grant = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        sum   = 0;
        idx   = '0;
        stg_d = (stg_q != '0) ? stg_q - SW'(1) : '0;
        if (stg_q == '0) begin
            for (int unsigned k = 0; k < N_DOM; k++) begin
                sum = 32'(ptr_q) + k;
                if (sum >= N_DOM) sum = sum - N_DOM;
                idx = PW'(sum);
                if (!found && pending[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = (sum == N_DOM - 1) ? '0 : PW'(sum + 1);
                    stg_d      = SW'(STAGGER_CYC);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ptr_q <= '0;
            stg_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            stg_q <= stg_d;
        end
    end

    for (genvar g = 0; g < N_DOM; g++) begin : g_dom
        icg_dom_fsm #(
            .WAKE_CYC (WAKE_CYC),
            .IDLE_CYC (IDLE_CYC)
        ) u_fsm (
            .CLK     (CLK),
            .RN      (RN),
            .grant   (grant[g]),
            .req     (req[g]),
            .busy    (busy[g]),
            .gate_en (gate_q[g]),
            .ack     (ack[g]),
            .dom_on  (dom_on[g]),
            .pending (pending[g])
        );
    end

    assign gate_en = gate_q | {N_DOM{TE}};

endmodule

// File: tb/tb_icg_enable_sequencer.sv
// Directed self-checking bench for icg_enable_sequencer with default parameters.
module tb_icg_enable_sequencer;

    logic       CLK;
    logic       RN;
    logic       TE;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] gate_en;
    logic [3:0] ack;
    logic [3:0] dom_on;

    int vectors = 0;
    int miscompares = 0;

    icg_enable_sequencer #(
        .N_DOM       (4),
        .WAKE_CYC    (2),
        .IDLE_CYC    (16),
        .STAGGER_CYC (4)
    ) dut (
        .CLK     (CLK),
        .RN      (RN),
        .TE      (TE),
        .req     (req),
        .busy    (busy),
        .gate_en (gate_en),
        .ack     (ack),
        .dom_on  (dom_on)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        RN   = 1'b0;
        TE   = 1'b0;
        req  = 4'b0000;
        busy = 4'b0000;
        #3;
        check("reset gate_en", gate_en, 4'b0000);
        check("reset ack", ack, 4'b0000);
        check("reset dom_on", dom_on, 4'b0000);
        #5 RN = 1'b1;
        tick(2);

        // Wake timing on domain 0.
        req = 4'b0001;
        tick(1);
        check("wake gate_en", gate_en, 4'b0001);
        check("wake dom_on", dom_on, 4'b0001);
        check("wake ack early", ack, 4'b0000);
        tick(1);
        check("wake ack edge1", ack, 4'b0000);
        tick(1);
        check("wake ack edge2", ack, 4'b0001);

        // Stagger + round robin: pointer at 1, stagger counter currently 2.
        req = 4'b1111;
        tick(2);
        check("stagger hold", gate_en, 4'b0001);
        tick(1);
        check("grant dom1", gate_en, 4'b0011);
        tick(4);
        check("stagger hold2", gate_en, 4'b0011);
        tick(1);
        check("grant dom2", gate_en, 4'b0111);
        tick(4);
        check("stagger hold3", gate_en, 4'b0111);
        tick(1);
        check("grant dom3", gate_en, 4'b1111);
        check("acks before dom3", ack, 4'b0111);
        tick(1);
        check("ack3 pending", ack, 4'b0111);
        tick(1);
        check("ack3 risen", ack, 4'b1111);

        // Idle timeout with busy reload on domain 1.
        req = 4'b1101;
        tick(1);
        check("idle ack drop", ack, 4'b1101);
        check("idle gate held", gate_en, 4'b1111);
        tick(5);
        busy = 4'b0010;
        tick(3);
        busy = 4'b0000;
        tick(15);
        check("idle not expired", gate_en, 4'b1111);
        tick(1);
        check("idle expired gate", gate_en, 4'b1101);
        check("idle expired dom_on", dom_on, 4'b1101);

        // Domain 2 re-requested from IDLE; domain 1 granted on the same edge.
        req = 4'b1001;
        tick(1);
        check("dom2 idle ack", ack, 4'b1001);
        tick(4);
        req = 4'b1111;
        tick(1);
        check("reack no grant", ack, 4'b1101);
        check("dom1 regrant", gate_en, 4'b1111);
        tick(2);
        check("all acked", ack, 4'b1111);

        // Everyone idles out together, then pointer (now 2) picks domain 2 first.
        req = 4'b0000;
        tick(1);
        check("all idle ack", ack, 4'b0000);
        tick(15);
        check("all idle held", gate_en, 4'b1111);
        tick(1);
        check("all closed", gate_en, 4'b0000);
        req = 4'b0101;
        tick(1);
        check("rr dom2 first", gate_en, 4'b0100);
        tick(4);
        check("rr stagger", gate_en, 4'b0100);
        tick(1);
        check("rr dom0 next", gate_en, 4'b0101);

        // Asynchronous reset while domain 0 is in WAKE.
        #2 RN = 1'b0;
        #1;
        check("async rst gate_en", gate_en, 4'b0000);
        check("async rst ack", ack, 4'b0000);
        check("async rst dom_on", dom_on, 4'b0000);
        #1 RN = 1'b1;
        tick(1);
        check("post rst grant", gate_en, 4'b0001);

        // Test enable override with all domains off.
        req = 4'b0000;
        tick(25);
        check("pre te gate_en", gate_en, 4'b0000);
        TE = 1'b1;
        #1;
        check("te gate_en", gate_en, 4'b1111);
        check("te ack", ack, 4'b0000);
        tick(1);
        check("te dom_on", dom_on, 4'b0000);
        check("te ack edge", ack, 4'b0000);
        TE = 1'b0;
        #1;
        check("te off gate_en", gate_en, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
